// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage plus the IF/ID pipeline register.
//
// Holds the PC, requests instruction words from the imem port and hands the
// fetched word together with its PC+4 to the decoder. It reacts to a stall
// from ID, a redirect (taken branch or jump) from EX, and a halt.
//
// Optional feature: define FETCH_SKID_EN to add a one-entry skid buffer.
// With the skid, a word that arrives while ID is stalled is captured rather
// than re-requested, and the stage parks in HOLD until ID can take it.
// Without it, that word is dropped and the same address is requested again.
//
// Event priority within one cycle: redirect > halt > id_stall > ihit.
// A redirect is ignored once the stage is HALTED; only nRST leaves HALTED.

module fetch_stage #(
    parameter int                 WORD_W  = 32,
    parameter logic [WORD_W-1:0]  PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    // instruction memory port
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    // pipeline control
    input  logic              id_stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    // IF/ID register towards decode
    output logic [WORD_W-1:0] instr_out,
    output logic [WORD_W-1:0] npc_out,
    output logic              if_valid
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
`ifdef FETCH_SKID_EN
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HALTED = 2'd2
    } state_t;
`endif

    state_t state;
    state_t state_next;

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] redirect_target;

    // Decoded per-cycle events, already resolved by priority.
    logic take_redirect;
    logic take_halt;
    logic is_fetch;

    // Wraps naturally modulo 2^WORD_W, so 0xFFFF_FFFC + 4 becomes 0.
    assign pc_plus4        = pc + WORD_W'(4);
    // Targets are forced to word alignment; the low two bits are dropped.
    assign redirect_target = redirect_pc & ~WORD_W'(3);

    assign take_redirect = redirect && (state != S_HALTED);
    assign take_halt     = halt && !take_redirect && (state != S_HALTED);
    assign is_fetch      = (state == S_FETCH);

    // The request address is always the current PC.
    assign iaddr = pc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // Holds the FSM state; reset lands in FETCH.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values of the others, independent of block order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Chooses the next state from redirect, halt, stall and hit, in that order.
    // NOTE: every combinational output gets a default first so that no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (redirect) begin
                    state_next = S_FETCH;
                end else if (halt) begin
                    state_next = S_HALTED;
`ifdef FETCH_SKID_EN
                end else if (id_stall && ihit) begin
                    state_next = S_HOLD;
`endif
                end else begin
                    state_next = S_FETCH;
                end
            end
`ifdef FETCH_SKID_EN
            S_HOLD: begin
                if (redirect) begin
                    state_next = S_FETCH;
                end else if (halt) begin
                    state_next = S_HALTED;
                end else if (!id_stall) begin
                    state_next = S_FETCH;
                end else begin
                    state_next = S_HOLD;
                end
            end
`endif
            S_HALTED: begin
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    // Read request depends on state only, and is suppressed while in reset.
    always_comb begin
        iREN = 1'b0;
        if (nRST && (state == S_FETCH)) begin
            iREN = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------
    // Advances on an accepted (or skid-captured) word, jumps on redirect,
    // and otherwise holds; a halt freezes it where it is.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc <= PC_INIT;
        end else if (take_redirect) begin
            pc <= redirect_target;
        end else if (take_halt) begin
            pc <= pc;
        end else if (is_fetch && ihit) begin
`ifdef FETCH_SKID_EN
            // With the skid, a hit is consumed whether or not ID stalls.
            pc <= pc_plus4;
`else
            // Without the skid, a hit under stall is dropped and re-requested.
            if (!id_stall) begin
                pc <= pc_plus4;
            end
`endif
        end
    end

`ifdef FETCH_SKID_EN
    // ------------------------------------------------------------------
    // Skid buffer (one entry)
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] skid_instr;
    logic [WORD_W-1:0] skid_npc;

    // Captures a word that arrives while ID is stalled; the HOLD state
    // itself marks the entry as full, so no separate valid bit is kept.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            skid_instr <= '0;
            skid_npc   <= '0;
        end else if (is_fetch && !redirect && !halt && id_stall && ihit) begin
            skid_instr <= iload;
            skid_npc   <= pc_plus4;
        end
    end
`endif

    // ------------------------------------------------------------------
    // IF/ID pipeline register
    // ------------------------------------------------------------------
    // Loads a fetched word, loads a bubble, or holds while ID stalls.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_out <= '0;
            npc_out   <= '0;
            if_valid  <= 1'b0;
        end else if (take_redirect || take_halt || (state == S_HALTED)) begin
            // Redirect overrides a stall: the wrong-path word must not survive.
            instr_out <= '0;
            npc_out   <= '0;
            if_valid  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!id_stall) begin
                        if (ihit) begin
                            instr_out <= iload;
                            npc_out   <= pc_plus4;
                            if_valid  <= 1'b1;
                        end else begin
                            instr_out <= '0;
                            npc_out   <= '0;
                            if_valid  <= 1'b0;
                        end
                    end
                end
`ifdef FETCH_SKID_EN
                S_HOLD: begin
                    if (!id_stall) begin
                        instr_out <= skid_instr;
                        npc_out   <= skid_npc;
                        if_valid  <= 1'b1;
                    end
                end
`endif
                default: begin
                    instr_out <= instr_out;
                    npc_out   <= npc_out;
                    if_valid  <= if_valid;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage.
// Directed table and hand-written sequences first, then randomized traffic
// compared against a behavioural model built from the stage's rules.
// Honours FETCH_SKID_EN the same way the design does.

module tb_fetch_stage;

    localparam logic [31:0] TAG = 32'h5A00_0013;
`ifdef FETCH_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] instr_out;
    logic [31:0] npc_out;
    logic        if_valid;

    int total = 0;
    int bad   = 0;

    fetch_stage #(.WORD_W(32), .PC_INIT(32'h0)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ihit       (ihit),
        .iload      (iload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .id_stall   (id_stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .instr_out  (instr_out),
        .npc_out    (npc_out),
        .if_valid   (if_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction memory: each word is tagged with its own address.
    always_comb iload = iaddr ^ TAG;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // One directed cycle: drive, check request side before the edge,
    // then check the IF/ID register just after it.
    task automatic step(input logic h, input logic s, input logic r,
                        input logic [31:0] rp, input logic hl,
                        input logic [31:0] e_addr, input logic e_ren,
                        input logic [31:0] e_instr, input logic [31:0] e_npc,
                        input logic e_valid, input string nm);
        ihit = h; id_stall = s; redirect = r; redirect_pc = rp; halt = hl;
        @(negedge CLK);
        check({nm, "_iaddr"}, iaddr, e_addr);
        check({nm, "_iren"}, 32'(iREN), 32'(e_ren));
        @(posedge CLK);
        #1;
        check({nm, "_instr"}, instr_out, e_instr);
        check({nm, "_npc"}, npc_out, e_npc);
        check({nm, "_valid"}, 32'(if_valid), 32'(e_valid));
    endtask

    task automatic do_reset();
        ihit = 1'b0; id_stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        nRST = 1'b0;
        #1;
        check("rst_iren", 32'(iREN), 32'd0);
        check("rst_iaddr", iaddr, 32'h0);
        check("rst_instr", instr_out, 32'h0);
        check("rst_npc", npc_out, 32'h0);
        check("rst_valid", 32'(if_valid), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model for the random phase
    // ------------------------------------------------------------------
    typedef struct packed { logic [31:0] instr; logic [31:0] npc; } word_t;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_npc;
    logic        m_valid;
    bit          m_halted;
    word_t       m_skid[$];

    function automatic bit m_ren();
        return !m_halted && (m_skid.size() == 0);
    endfunction

    task automatic m_reset();
        m_pc = 32'h0; m_instr = '0; m_npc = '0; m_valid = 1'b0;
        m_halted = 1'b0; m_skid.delete();
    endtask

    task automatic m_bubble();
        m_instr = '0; m_npc = '0; m_valid = 1'b0;
    endtask

    task automatic m_cycle(input logic h, input logic s, input logic r,
                           input logic [31:0] rp, input logic hl);
        word_t w;
        if (!m_halted && r) begin
            m_pc = {rp[31:2], 2'b00};
            m_bubble();
            m_skid.delete();
        end else if (!m_halted && hl) begin
            m_halted = 1'b1;
            m_bubble();
            m_skid.delete();
        end else if (m_halted) begin
            m_bubble();
        end else if (m_skid.size() != 0) begin
            if (!s) begin
                w = m_skid.pop_front();
                m_instr = w.instr; m_npc = w.npc; m_valid = 1'b1;
            end
        end else if (s) begin
            if (SKID && h) begin
                m_skid.push_back('{instr: m_pc ^ TAG, npc: m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
            end
        end else if (h) begin
            m_instr = m_pc ^ TAG; m_npc = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end else begin
            m_bubble();
        end
    endtask

    task automatic rstep(input logic h, input logic s, input logic r,
                         input logic [31:0] rp, input logic hl);
        ihit = h; id_stall = s; redirect = r; redirect_pc = rp; halt = hl;
        @(negedge CLK);
        check("rand_iaddr", iaddr, m_pc);
        check("rand_iren", 32'(iREN), 32'(m_ren()));
        @(posedge CLK);
        m_cycle(h, s, r, rp, hl);
        #1;
        check("rand_instr", instr_out, m_instr);
        check("rand_npc", npc_out, m_npc);
        check("rand_valid", 32'(if_valid), 32'(m_valid));
    endtask

    // ------------------------------------------------------------------
    // Directed table
    // ------------------------------------------------------------------
    typedef struct {
        logic        ihit, stall, redir;
        logic [31:0] rpc;
        logic        hlt;
        logic [31:0] addr;
        logic        ren;
        logic [31:0] instr, npc;
        logic        valid;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1, 0, 0, 0, 0, 32'h00, 1, TAG ^ 32'h00, 32'h04, 1};
        tbl[1] = '{1, 0, 0, 0, 0, 32'h04, 1, TAG ^ 32'h04, 32'h08, 1};
        tbl[2] = '{0, 0, 0, 0, 0, 32'h08, 1, 32'h0,        32'h00, 0};
        tbl[3] = '{0, 0, 0, 0, 0, 32'h08, 1, 32'h0,        32'h00, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 32'h08, 1, 32'h0,        32'h00, 0};
        tbl[5] = '{1, 0, 0, 0, 0, 32'h08, 1, TAG ^ 32'h08, 32'h0C, 1};
        tbl[6] = '{1, 0, 0, 0, 0, 32'h0C, 1, TAG ^ 32'h0C, 32'h10, 1};

        ihit = 1'b0; id_stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        do_reset();

        // Sequential fetch, then three misses at pc=8, then resume.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].ihit, tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].hlt,
                 tbl[i].addr, tbl[i].ren, tbl[i].instr, tbl[i].npc, tbl[i].valid,
                 $sformatf("tbl%0d", i));
        end

        // Two stalled cycles with hits at pc=0x10, then the stall drops.
        step(1, 1, 0, 0, 0, 32'h10, 1, TAG ^ 32'h0C, 32'h10, 1, "stall0");
        if (SKID) begin
            step(1, 1, 0, 0, 0, 32'h14, 0, TAG ^ 32'h0C, 32'h10, 1, "stall1");
            step(1, 0, 0, 0, 0, 32'h14, 0, TAG ^ 32'h10, 32'h14, 1, "stall_rel");
        end else begin
            step(1, 1, 0, 0, 0, 32'h10, 1, TAG ^ 32'h0C, 32'h10, 1, "stall1");
            step(1, 0, 0, 0, 0, 32'h10, 1, TAG ^ 32'h10, 32'h14, 1, "stall_rel");
        end
        step(1, 0, 0, 0, 0, 32'h14, 1, TAG ^ 32'h14, 32'h18, 1, "post_stall");

        // Redirect beats a stall and drops the low address bits.
        step(1, 1, 1, 32'h43, 0, 32'h18, 1, 32'h0, 32'h0, 0, "redir");
        step(0, 0, 0, 0, 0, 32'h40, 1, 32'h0, 32'h0, 0, "redir_tgt");

        // Redirect during a skid HOLD drops the captured word.
        step(1, 1, 0, 0, 0, 32'h40, 1, 32'h0, 32'h0, 0, "hold_in");
        step(1, 1, 1, 32'h80, 0, SKID ? 32'h44 : 32'h40, !SKID, 32'h0, 32'h0, 0, "hold_redir");
        step(1, 0, 0, 0, 0, 32'h80, 1, TAG ^ 32'h80, 32'h84, 1, "hold_after");

        // Address wrap at the top of the space.
        step(0, 0, 1, 32'hFFFF_FFFF, 0, 32'h84, 1, 32'h0, 32'h0, 0, "wrap_redir");
        step(1, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, TAG ^ 32'hFFFF_FFFC, 32'h0, 1, "wrap_hit");
        step(1, 0, 0, 0, 0, 32'h0, 1, TAG ^ 32'h0, 32'h4, 1, "wrap_next");

        // Halt freezes the pc and ignores later redirects.
        step(1, 1, 0, 0, 1, 32'h4, 1, 32'h0, 32'h0, 0, "halt");
        step(1, 0, 0, 0, 0, 32'h4, 0, 32'h0, 32'h0, 0, "halted0");
        step(1, 0, 1, 32'h100, 0, 32'h4, 0, 32'h0, 32'h0, 0, "halted_redir");
        step(1, 0, 0, 0, 0, 32'h4, 0, 32'h0, 32'h0, 0, "halted2");

        // Mid-cycle reset leaves HALTED and restarts from PC_INIT.
        do_reset();
        step(1, 0, 0, 0, 0, 32'h0, 1, TAG ^ 32'h0, 32'h4, 1, "restart");

        // ------------------------------------------------------------------
        // Randomized traffic against the model
        // ------------------------------------------------------------------
        do_reset();
        m_reset();
        for (int i = 0; i < 1500; i++) begin
            logic        h, s, r, hl;
            logic [31:0] rp;
            if ((i % 250) == 249) begin
                do_reset();
                m_reset();
            end
            h  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 15) == 0);
            hl = ($urandom_range(0, 199) == 0);
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
            rstep(h, s, r, rp, hl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
